riscv_lsu: RTL and testbench
============================

RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (synchronous active-low reset).
REQ-002 req_valid input 1: core load/store request, qualified by req_ready.
REQ-003 req_ready output 1: LSU can accept a request this cycle.
REQ-004 req_we input 1: 1 = store, 0 = load.
REQ-005 req_size input 2: 00 byte, 01 half, 10 word; 11 handled as word.
REQ-006 req_unsigned input 1: 1 = zero-extend load data, 0 = sign-extend.
REQ-007 req_addr input 32: byte address, taken from ALU result.
REQ-008 req_wdata input 32: store data, right-aligned in the low bits.
REQ-009 resp_valid output 1: one-cycle pulse marking completion.
REQ-010 resp_rdata output 32: extended load data; 0 for stores and errors.
REQ-011 resp_err output 1: misaligned-access flag, valid with resp_valid.
REQ-012 mem_valid output 1: memory request, held until mem_ready.
REQ-013 mem_ready input 1: memory accepts or completes the request.
REQ-014 mem_addr output 32: {req_addr[31:2],2'b00}.
REQ-015 mem_we output 1; mem_wstrb output 4; mem_wdata output 32; mem_rdata input 32.

Function
REQ-016 FSM states SHALL be IDLE, BUS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, req_valid=1: the LSU SHALL latch all req_* inputs and go to BUS; misaligned with the macro defined: go to RESP with resp_err=1.
REQ-018 BUS: mem_valid=1, with mem_addr, mem_we, mem_wstrb and mem_wdata stable from latched values until the mem_ready cycle.
REQ-019 BUS with mem_ready=1: capture mem_rdata, go to RESP; mem_valid SHALL be 0 the following cycle.
REQ-020 RESP: resp_valid=1 for exactly one cycle, then IDLE.
REQ-021 Minimum latency SHALL be 2 cycles (req at edge N, resp_valid at N+2); misaligned trap latency SHALL be 1 cycle.
REQ-022 Byte lane SHALL be addr[1:0]; half lane SHALL be addr[1].
REQ-023 Store wstrb SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-024 mem_wdata SHALL replicate the data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-025 Load data SHALL select the addressed lane and extend it to 32 bits per req_unsigned; word loads SHALL pass unchanged.
REQ-026 Loads SHALL drive mem_wstrb=0000 and mem_we=0.
REQ-027 req_valid outside IDLE SHALL be ignored and SHALL cause no state change.
REQ-028 mem_ready outside BUS SHALL be ignored.
REQ-029 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=00.

Reset
REQ-030 With rst_n=0 at a clk edge: state=IDLE; resp_valid, resp_err, mem_valid, mem_we=0; mem_wstrb=0000; resp_rdata, mem_addr, mem_wdata=0.
REQ-031 Reset in BUS SHALL abandon the access; mem_valid SHALL be 0 from the next cycle; no resp_valid SHALL be generated.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: misaligned requests SHALL produce no memory access and SHALL complete with resp_err=1 and resp_rdata=0.
REQ-033 Macro LSU_MISALIGN_TRAP_EN undefined: the LSU SHALL force low address bits to size alignment (half clears bit0; word clears bits1:0), proceed normally, and tie resp_err to 0.

Verification
REQ-034 Word store 0xDEADBEEF @0x100, mem_ready on the first BUS cycle -> mem_addr=0x100, wstrb=1111, resp_valid 2 cycles after acceptance.
REQ-035 Signed byte load @0x103, mem_rdata=0x80FF_FF7F -> resp_rdata=0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-036 Half store 0x1234 @0x22 -> mem_addr=0x20, wstrb=1100, mem_wdata=0x12341234.
REQ-037 mem_ready held low 3 BUS cycles -> mem_valid and payload stable for 4 cycles, a new req_valid is ignored, one resp_valid.
REQ-038 Word load @0x101 -> macro defined: resp_err=1 at cycle N+1, no mem_valid; macro undefined: access to 0x100, resp_err=0.
REQ-039 rst_n=0 during BUS -> next cycle state IDLE, mem_valid=0, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit between a RISC-V core and a
// 32-bit word-addressed memory port.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to complete misaligned
// accesses with an error and no memory access. With it undefined, the
// address is forced to size alignment and resp_err stays 0.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   i_req_*             core request (valid/ready handshake, we, size,
//                       unsigned, addr, wdata)
//   o_resp_*            one-cycle completion pulse, extended load data, error
//   o_mem_* / i_mem_*   memory request held until i_mem_ready, read data in
module riscv_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_req_ready, w_req_ready_nxt;
  logic                r_we, w_we_nxt;
  logic [1:0]          r_size, w_size_nxt;
  logic                r_unsigned, w_unsigned_nxt;
  logic [1:0]          r_lane, w_lane_nxt;
  logic                r_resp_valid, w_resp_valid_nxt;
  logic                r_resp_err, w_resp_err_nxt;
  logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_nxt;
  logic                r_mem_valid, w_mem_valid_nxt;
  logic [DATA_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [STRB_W-1:0]   r_mem_wstrb, w_mem_wstrb_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;

  logic                w_is_half;
  logic                w_is_word;
  logic [DATA_W-1:0]   w_addr_al;
  logic [STRB_W-1:0]   w_strb;
  logic [DATA_W-1:0]   w_wdata_rep;
  logic                w_misal;
  logic [7:0]          w_ld_byte;
  logic [15:0]         w_ld_half;
  logic [DATA_W-1:0]   w_ld_ext;

  // Request decode: size class, size-aligned address, lane strobes, replicated store data.
  always_comb begin
    w_is_half   = (i_req_size == 2'b01);
    w_is_word   = i_req_size[1];
    w_addr_al   = i_req_addr;
    w_strb      = 4'b1111;
    w_wdata_rep = i_req_wdata;
    w_misal     = 1'b0;
    if (w_is_word) begin
      w_addr_al[1:0] = 2'b00;
    end else if (w_is_half) begin
      w_addr_al[0] = 1'b0;
      w_strb       = w_addr_al[1] ? 4'b1100 : 4'b0011;
      w_wdata_rep  = {2{i_req_wdata[15:0]}};
    end else begin
      w_strb      = STRB_W'(4'b0001 << i_req_addr[1:0]);
      w_wdata_rep = {4{i_req_wdata[7:0]}};
    end
`ifdef LSU_MISALIGN_TRAP_EN
    w_misal = (w_is_half & i_req_addr[0]) | (w_is_word & (|i_req_addr[1:0]));
`endif
  end

  // Load lane select and sign/zero extension of the returned word.
  always_comb begin
    w_ld_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_lane)
      2'd0:    w_ld_byte = i_mem_rdata[7:0];
      2'd1:    w_ld_byte = i_mem_rdata[15:8];
      2'd2:    w_ld_byte = i_mem_rdata[23:16];
      default: w_ld_byte = i_mem_rdata[31:24];
    endcase
    if (r_size[1]) begin
      w_ld_ext = i_mem_rdata;
    end else if (r_size == 2'b01) begin
      w_ld_ext = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
    end else begin
      w_ld_ext = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = r_we;
    w_size_nxt       = r_size;
    w_unsigned_nxt   = r_unsigned;
    w_lane_nxt       = r_lane;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_mem_valid_nxt  = r_mem_valid;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_we_nxt     = r_mem_we;
    w_mem_wstrb_nxt  = r_mem_wstrb;
    w_mem_wdata_nxt  = r_mem_wdata;

    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_we_nxt       = i_req_we;
          w_size_nxt     = i_req_size;
          w_unsigned_nxt = i_req_unsigned;
          w_lane_nxt     = w_addr_al[1:0];
          if (w_misal) begin
            // Trap: complete immediately with an error, never touch memory.
            w_state_nxt      = RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = '0;
          end else begin
            w_state_nxt     = BUS;
            w_mem_valid_nxt = 1'b1;
            w_mem_addr_nxt  = {w_addr_al[31:2], 2'b00};
            w_mem_we_nxt    = i_req_we;
            w_mem_wstrb_nxt = i_req_we ? w_strb : 4'b0000;
            w_mem_wdata_nxt = i_req_we ? w_wdata_rep : '0;
          end
        end
      end
      BUS: begin
        if (i_mem_ready) begin
          w_state_nxt      = RESP;
          w_mem_valid_nxt  = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = r_we ? '0 : w_ld_ext;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_mem_valid_nxt = 1'b0;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_we         <= w_we_nxt;
      r_size       <= w_size_nxt;
      r_unsigned   <= w_unsigned_nxt;
      r_lane       <= w_lane_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;
  assign o_mem_valid  = r_mem_valid;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_we     = r_mem_we;
  assign o_mem_wstrb  = r_mem_wstrb;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: randomized and directed bench for riscv_lsu. Each transaction
// posts the expected outputs for every cycle it occupies into a cycle-indexed
// table; one compare process checks the DUT against that table (or against
// the idle defaults) on every falling edge. Honours LSU_MISALIGN_TRAP_EN.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;

  riscv_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_err(o_resp_err),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        ready;
    logic        mval;
    logic        mwe;
    logic        cwd;
    logic [3:0]  strb;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        rval;
    logic        rerr;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_a [int];
  exp_t ce;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  logic [31:0] last_maddr, last_wdata, last_rdata;
  logic [3:0]  last_strb;
  logic        last_mval, last_rval, last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Compare process: table entry if one exists, idle defaults otherwise.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_a.exists(cyc)) begin
        ce = exp_a[cyc];
        exp_a.delete(cyc);
        chk("req_ready", 32'(o_req_ready), 32'(ce.ready));
        chk("mem_valid", 32'(o_mem_valid), 32'(ce.mval));
        chk("resp_valid", 32'(o_resp_valid), 32'(ce.rval));
        if (ce.mval) begin
          chk("mem_addr", o_mem_addr, ce.maddr);
          chk("mem_we", 32'(o_mem_we), 32'(ce.mwe));
          chk("mem_wstrb", 32'(o_mem_wstrb), 32'(ce.strb));
          if (ce.cwd) chk("mem_wdata", o_mem_wdata, ce.mwdata);
        end
        if (ce.rval) begin
          chk("resp_rdata", o_resp_rdata, ce.rdata);
          chk("resp_err", 32'(o_resp_err), 32'(ce.rerr));
        end
      end else begin
        chk("idle_ready", 32'(o_req_ready), 32'd1);
        chk("idle_mem_valid", 32'(o_mem_valid), 32'd0);
        chk("idle_resp_valid", 32'(o_resp_valid), 32'd0);
      end
    end
  end

  // Reference load result: pick the lane by shifting, then extend.
  function automatic logic [31:0] load_model(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] ea, input logic [31:0] rd);
    logic [31:0] v;
    if (sz[1]) return rd;
    if (sz == 2'b00) begin
      v = (rd >> (8 * ea[1:0])) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (rd >> (16 * ea[1])) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Random request presented while the LSU is busy; must have no effect.
  task automatic junk(input bit jk);
    i_req_valid = jk ? 1'($urandom) : 1'b0;
    if (jk) begin
      i_req_we       = 1'($urandom);
      i_req_size     = 2'($urandom);
      i_req_unsigned = 1'($urandom);
      i_req_addr     = $urandom;
      i_req_wdata    = $urandom;
    end
  endtask

  // One request from an idle falling edge; returns at the next idle falling edge.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int dly, input bit jk);
    logic        mis, trap;
    logic [31:0] ea;
    exp_t        e;
    int          a;
    mis = ((sz == 2'b01) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`endif
    ea = addr;
    if (sz == 2'b01) ea = ea & 32'hFFFF_FFFE;
    else if (sz[1]) ea = ea & 32'hFFFF_FFFC;
    last_maddr = '0; last_wdata = '0; last_strb = '0; last_mval = 1'b0;
    a = cyc + 1;
    i_req_valid = 1'b1; i_req_we = we; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wd;
    i_mem_ready = 1'($urandom); i_mem_rdata = $urandom;
    e = '0;
    if (trap) begin
      e.rval = 1'b1; e.rerr = 1'b1; e.rdata = '0;
      exp_a[a] = e;
      @(negedge clk);
      last_rval = o_resp_valid; last_err = o_resp_err; last_rdata = o_resp_rdata;
      junk(jk);
      i_mem_ready = 1'($urandom);
      @(negedge clk);
    end else begin
      e.mval = 1'b1; e.mwe = we; e.cwd = we;
      e.maddr = {ea[31:2], 2'b00};
      if (!we) e.strb = 4'b0000;
      else if (sz == 2'b00) e.strb = 4'(4'b0001 << ea[1:0]);
      else if (sz == 2'b01) e.strb = ea[1] ? 4'b1100 : 4'b0011;
      else e.strb = 4'b1111;
      if (sz == 2'b00) e.mwdata = {4{wd[7:0]}};
      else if (sz == 2'b01) e.mwdata = {2{wd[15:0]}};
      else e.mwdata = wd;
      for (int i = 0; i <= dly; i++) exp_a[a + i] = e;
      e = '0;
      e.rval = 1'b1; e.rerr = 1'b0;
      e.rdata = we ? 32'h0 : load_model(sz, uns, ea, rd);
      exp_a[a + dly + 1] = e;
      for (int i = 0; i <= dly; i++) begin
        @(negedge clk);
        if (i == 0) begin
          last_maddr = o_mem_addr; last_wdata = o_mem_wdata;
          last_strb = o_mem_wstrb; last_mval = o_mem_valid;
        end
        junk(jk);
        i_mem_ready = (i == dly);
        i_mem_rdata = (i == dly) ? rd : $urandom;
      end
      @(negedge clk);
      last_rval = o_resp_valid; last_err = o_resp_err; last_rdata = o_resp_rdata;
      junk(jk);
      i_mem_ready = 1'($urandom); i_mem_rdata = $urandom;
      @(negedge clk);
    end
    i_req_valid = 1'b0;
  endtask

  initial begin
    // Reset and reset-state values.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(o_mem_wstrb), 32'h0);
    chk("rst_resp_rdata", o_resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(o_resp_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store, minimum latency.
    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, $urandom, 0, 1'b0);
    chk("ws_addr", last_maddr, 32'h100);
    chk("ws_strb", 32'(last_strb), 32'hF);
    chk("ws_wdata", last_wdata, 32'hDEADBEEF);
    chk("ws_resp_at_n2", 32'(last_rval), 32'h1);

    // Byte loads, signed and unsigned.
    xact(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 1, 1'b0);
    chk("lb_signed", last_rdata, 32'hFFFF_FF80);
    xact(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 1'b0);
    chk("lbu", last_rdata, 32'h0000_0080);

    // Half store to upper lane.
    xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, $urandom, 0, 1'b0);
    chk("hs_addr", last_maddr, 32'h20);
    chk("hs_strb", 32'(last_strb), 32'hC);
    chk("hs_wdata", last_wdata, 32'h1234_1234);

    // Three wait cycles with stray requests while busy.
    xact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1357_9BDF, 3, 1'b1);
    chk("stall_rdata", last_rdata, 32'h1357_9BDF);

    // Misaligned word load.
    xact(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", 32'(last_err), 32'h1);
    chk("mis_rdata", last_rdata, 32'h0);
    chk("mis_no_mem", 32'(last_mval), 32'h0);
`else
    chk("mis_addr", last_maddr, 32'h100);
    chk("mis_err", 32'(last_err), 32'h0);
    chk("mis_rdata", last_rdata, 32'hCAFE_F00D);
`endif

    // Reset during BUS abandons the access.
    begin
      exp_t e;
      int a;
      a = cyc + 1;
      e = '0;
      e.mval = 1'b1; e.maddr = 32'h200;
      exp_a[a] = e;
      i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'b10;
      i_req_addr = 32'h200; i_mem_ready = 1'b0;
      @(negedge clk);
      i_req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstbus_mem_addr", o_mem_addr, 32'h0);
      chk("rstbus_ready", 32'(o_req_ready), 32'h1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
    end

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [1:0] sz;
      sz = 2'($urandom);
      xact(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
           int'($urandom_range(0, 4)), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        i_req_valid = 1'b0;
        i_mem_ready = 1'($urandom);
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
